// File: rtl/lcd_nibble_writer.sv
// Byte-level write sequencer for an HD44780-compatible LCD in 4-bit mode.
// A byte is split into high and low nibbles, each strobed with lcd_e under
// programmable setup/pulse/gap timing, followed by a command execution wait.
// Single-nibble writes (high nibble only) serve the power-on init sequence.
module lcd_nibble_writer #(
   parameter int SETUP_CYCLES     = 2,
   parameter int E_HIGH_CYCLES    = 12,
   parameter int GAP_CYCLES       = 50,
   parameter int WAIT_CYCLES      = 2000,
   parameter int LONG_WAIT_CYCLES = 82000,
   parameter int CNT_W            = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_byte,
   input  logic       in_rs,
   input  logic       in_nib_only,
   input  logic       in_long,
   output logic       done,
   output logic       lcd_rs,
   output logic       lcd_w,
   output logic       lcd_e,
   output logic [3:0] data
);

   typedef enum logic [2:0] {
      IDLE,
      HI_SETUP,
      HI_E,
      GAP,
      LO_SETUP,
      LO_E,
      WAIT
   } state_t;

   // Phase lengths are loaded as length-1 and counted down to zero.
   localparam logic [CNT_W-1:0] S_LD = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] E_LD = CNT_W'(E_HIGH_CYCLES - 1);
   localparam logic [CNT_W-1:0] G_LD = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] W_LD = CNT_W'(WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] L_LD = CNT_W'(LONG_WAIT_CYCLES - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [3:0]       lo_nib, lo_nib_nxt;
   logic             nib_only, nib_only_nxt;
   logic             long_wait, long_wait_nxt;
   logic [3:0]       data_nxt;
   logic             rs_nxt;
   logic             e_nxt;
   logic             done_nxt;
   logic [CNT_W-1:0] wait_ld;

   assign in_ready = (state == IDLE);
   assign lcd_w    = 1'b0;
   assign wait_ld  = long_wait ? L_LD : W_LD;

   // Next-state, phase counter and next registered pin values.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      lo_nib_nxt    = lo_nib;
      nib_only_nxt  = nib_only;
      long_wait_nxt = long_wait;
      data_nxt      = data;
      rs_nxt        = lcd_rs;

      if (state == IDLE) begin
         if (in_valid) begin
            state_nxt     = HI_SETUP;
            cnt_nxt       = S_LD;
            data_nxt      = in_byte[7:4];
            rs_nxt        = in_rs;
            lo_nib_nxt    = in_byte[3:0];
            nib_only_nxt  = in_nib_only;
            long_wait_nxt = in_long;
         end
      end else if (cnt != '0) begin
         cnt_nxt = cnt - CNT_W'(1);
      end else begin
         case (state)
            HI_SETUP: begin
               state_nxt = HI_E;
               cnt_nxt   = E_LD;
            end
            HI_E: begin
               if (nib_only) begin
                  state_nxt = WAIT;
                  cnt_nxt   = wait_ld;
               end else begin
                  state_nxt = GAP;
                  cnt_nxt   = G_LD;
               end
            end
            GAP: begin
               state_nxt = LO_SETUP;
               cnt_nxt   = S_LD;
               data_nxt  = lo_nib;
            end
            LO_SETUP: begin
               state_nxt = LO_E;
               cnt_nxt   = E_LD;
            end
            LO_E: begin
               state_nxt = WAIT;
               cnt_nxt   = wait_ld;
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end

      // Pins are registered, so they are derived from the state being entered.
      e_nxt    = (state_nxt == HI_E) || (state_nxt == LO_E);
      done_nxt = (state_nxt == WAIT) && (cnt_nxt == '0);
   end

   // State, counter, captured request and registered LCD pins; reset drops lcd_e at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         lo_nib    <= '0;
         nib_only  <= 1'b0;
         long_wait <= 1'b0;
         data      <= '0;
         lcd_rs    <= 1'b0;
         lcd_e     <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         lo_nib    <= lo_nib_nxt;
         nib_only  <= nib_only_nxt;
         long_wait <= long_wait_nxt;
         data      <= data_nxt;
         lcd_rs    <= rs_nxt;
         lcd_e     <= e_nxt;
         done      <= done_nxt;
      end
   end

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Bench for lcd_nibble_writer: table-driven cycle checks, hand-written
// corner sequences and a random burst decoded by a pin-level LCD model.
module tb_lcd_nibble_writer;

   localparam int S  = 2;
   localparam int E  = 3;
   localparam int G  = 4;
   localparam int W  = 5;
   localparam int LW = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_byte = 8'h00;
   logic       in_rs = 1'b0;
   logic       in_nib_only = 1'b0;
   logic       in_long = 1'b0;
   logic       done;
   logic       lcd_rs;
   logic       lcd_w;
   logic       lcd_e;
   logic [3:0] data;

   lcd_nibble_writer #(
      .SETUP_CYCLES    (S),
      .E_HIGH_CYCLES   (E),
      .GAP_CYCLES      (G),
      .WAIT_CYCLES     (W),
      .LONG_WAIT_CYCLES(LW),
      .CNT_W           (20)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_byte    (in_byte),
      .in_rs      (in_rs),
      .in_nib_only(in_nib_only),
      .in_long    (in_long),
      .done       (done),
      .lcd_rs     (lcd_rs),
      .lcd_w      (lcd_w),
      .lcd_e      (lcd_e),
      .data       (data)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at a negedge with in_ready high or after the bound.
   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("wait_ready", int'(in_ready), 1);
   endtask

   // ---------------- pin-level LCD model ----------------
   logic       mon_en = 1'b0;
   logic       prev_e = 1'b0;
   logic [3:0] prev_d = 4'h0;
   logic       prev_rs = 1'b0;
   logic [3:0] hi_n = 4'h0;
   logic       hi_rs = 1'b0;
   logic       half = 1'b0;
   int         hi_cnt = 0;
   int         low_cnt = 1000;
   int         stable = 0;
   int         viol = 0;
   logic [8:0] dec_q[$];

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (lcd_e) begin
               if (!prev_e) begin
                  if (stable < S) viol++;
                  if (low_cnt < G + S) viol++;
                  hi_cnt = 1;
               end else begin
                  hi_cnt++;
                  if (data != prev_d || lcd_rs != prev_rs) viol++;
               end
            end else begin
               if (prev_e) begin
                  if (hi_cnt != E) viol++;
                  if (!half) begin
                     hi_n  = prev_d;
                     hi_rs = prev_rs;
                     half  = 1'b1;
                  end else begin
                     if (hi_rs != prev_rs) viol++;
                     dec_q.push_back({prev_rs, hi_n, prev_d});
                     half = 1'b0;
                  end
                  low_cnt = 1;
                  stable  = 1;
               end else begin
                  low_cnt++;
                  stable = (data == prev_d && lcd_rs == prev_rs) ? stable + 1 : 1;
               end
            end
            prev_e  = lcd_e;
            prev_d  = data;
            prev_rs = lcd_rs;
         end
      end
   end

   // ---------------- directed table ----------------
   typedef struct {
      logic [7:0] b;
      logic       rs;
      logic       nib;
      logic       lng;
      int         e1;
      int         e2;
      int         lo;
      int         dn;
      int         rdy;
   } vec_t;

   vec_t       vt[4];
   logic [8:0] exp_q[$];

   initial begin
      vt[0] = '{b: 8'h48, rs: 1'b1, nib: 1'b0, lng: 1'b0, e1: 3, e2: 12, lo: 10, dn: 19, rdy: 20};
      vt[1] = '{b: 8'h30, rs: 1'b0, nib: 1'b1, lng: 1'b0, e1: 3, e2: 0,  lo: 0,  dn: 10, rdy: 11};
      vt[2] = '{b: 8'h01, rs: 1'b0, nib: 1'b0, lng: 1'b1, e1: 3, e2: 12, lo: 10, dn: 34, rdy: 35};
      vt[3] = '{b: 8'hA5, rs: 1'b1, nib: 1'b1, lng: 1'b1, e1: 3, e2: 0,  lo: 0,  dn: 25, rdy: 26};

      // Reset state
      #12;
      chk("rst_lcd_e", int'(lcd_e), 0);
      chk("rst_lcd_rs", int'(lcd_rs), 0);
      chk("rst_lcd_w", int'(lcd_w), 0);
      chk("rst_data", int'(data), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", int'(in_ready), 1);

      // Table-driven single writes, inputs scrambled after acceptance
      foreach (vt[v]) begin
         wait_ready();
         in_byte     = vt[v].b;
         in_rs       = vt[v].rs;
         in_nib_only = vt[v].nib;
         in_long     = vt[v].lng;
         in_valid    = 1'b1;
         for (int c = 1; c <= vt[v].rdy; c++) begin
            logic       ee;
            logic [3:0] ed;
            @(negedge clk);
            ee = (c >= vt[v].e1 && c < vt[v].e1 + E) ||
                 (vt[v].e2 != 0 && c >= vt[v].e2 && c < vt[v].e2 + E);
            ed = (vt[v].lo != 0 && c >= vt[v].lo) ? vt[v].b[3:0] : vt[v].b[7:4];
            chk($sformatf("v%0d_lcd_e@%0d", v, c), int'(lcd_e), int'(ee));
            chk($sformatf("v%0d_data@%0d", v, c), int'(data), int'(ed));
            chk($sformatf("v%0d_rs@%0d", v, c), int'(lcd_rs), int'(vt[v].rs));
            chk($sformatf("v%0d_done@%0d", v, c), int'(done), int'(c == vt[v].dn));
            chk($sformatf("v%0d_ready@%0d", v, c), int'(in_ready), int'(c == vt[v].rdy));
            if (c == 1) begin
               in_valid    = 1'b0;
               in_byte     = ~vt[v].b;
               in_rs       = ~vt[v].rs;
               in_nib_only = ~vt[v].nib;
               in_long     = ~vt[v].lng;
            end
         end
      end

      // Back-to-back: in_valid held high with changing inputs while busy
      wait_ready();
      in_byte = 8'h48; in_rs = 1'b1; in_nib_only = 1'b0; in_long = 1'b0;
      in_valid = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         chk($sformatf("b2b_ready@%0d", c), int'(in_ready), int'(c == 20));
         if (c <= 9) chk($sformatf("b2b_data@%0d", c), int'(data), 4);
         if (c <= 19) chk($sformatf("b2b_rs@%0d", c), int'(lcd_rs), 1);
         if (c == 20) chk("b2b_data@20", int'(data), 8);
         in_byte = (c >= 19) ? 8'h9C : 8'(c * 37);
         in_rs   = (c >= 19) ? 1'b0 : ~in_rs;
      end
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (c == 1) begin
            chk("b2b2_ready@1", int'(in_ready), 0);
            in_valid = 1'b0;
         end
         chk($sformatf("b2b2_lcd_e@%0d", c), int'(lcd_e), int'(c >= 3));
         chk($sformatf("b2b2_data@%0d", c), int'(data), 9);
         chk($sformatf("b2b2_rs@%0d", c), int'(lcd_rs), 0);
      end

      // Reset asserted mid-pulse
      @(negedge clk);
      wait_ready();
      in_byte = 8'h5A; in_rs = 1'b1; in_nib_only = 1'b0; in_long = 1'b0;
      in_valid = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c == 1) in_valid = 1'b0;
      end
      chk("midrst_pre_e", int'(lcd_e), 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_lcd_e", int'(lcd_e), 0);
      chk("midrst_ready", int'(in_ready), 1);
      chk("midrst_data", int'(data), 0);
      chk("midrst_rs", int'(lcd_rs), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         chk($sformatf("after_rst_ready@%0d", c), int'(in_ready), 1);
         chk($sformatf("after_rst_e@%0d", c), int'(lcd_e), 0);
      end

      // Random burst decoded by the pin model
      mon_en = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 200; i++) begin
         int n;
         in_byte     = 8'($urandom_range(0, 255));
         in_rs       = 1'($urandom_range(0, 1));
         in_nib_only = 1'b0;
         in_long     = ($urandom_range(0, 3) == 0);
         in_valid    = 1'b1;
         n = 0;
         while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
         end
         if (!in_ready) begin
            chk("burst_accept_timeout", 0, 1);
         end else begin
            exp_q.push_back({in_rs, in_byte});
         end
         @(negedge clk);
         if ($urandom_range(0, 1) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
      end
      in_valid = 1'b0;
      wait_ready();
      repeat (2) @(negedge clk);
      mon_en = 1'b0;

      chk("burst_count", dec_q.size(), exp_q.size());
      chk("burst_expected_count", exp_q.size(), 200);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < dec_q.size())
            chk($sformatf("burst_byte%0d", i), int'(dec_q[i]), int'(exp_q[i]));
      end
      chk("timing_violations", viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time guard
   initial begin
      #500000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

endmodule
